// File: rtl/timer.sv
// Memory-mapped 32-bit timer/counter slave with an 8-bit prescaler, one-shot and
// periodic compare modes, write-1-to-clear match/overflow flags and a level interrupt.
// Register map (word-aligned, address bits [1:0] ignored):
//   0x0 CTRL    : bit0 EN, bit1 PERIODIC, bit2 IRQ_EN, bits[15:8] PRESCALE
//   0x4 COUNT   : running counter value
//   0x8 COMPARE : match value
//   0xC STATUS  : bit0 MATCH, bit1 OVF (write 1 to clear)
module timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  timer_address,
    input  logic [31:0] timer_data_i,
    input  logic [3:0]  timer_wr,
    input  logic        timer_enable,
    output logic [31:0] timer_data_o,
    output logic        timer_ready,
    output logic        timer_interrupt
);

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // Control register fields
    logic        en_q, en_d;
    logic        periodic_q, periodic_d;
    logic        irqEn_q, irqEn_d;
    logic [7:0]  prescale_q, prescale_d;

    // Counting state
    logic [7:0]  pcnt_q, pcnt_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;

    // Status flags
    logic        match_q, match_d;
    logic        ovf_q, ovf_d;

    // Bus response
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    // Decode and event strobes
    logic [1:0]  regSel;
    logic        access;
    logic        wrAny;
    logic        wrCtrl;
    logic        wrCount;
    logic        wrCompare;
    logic        wrStatus;
    logic        tick;
    logic        hitCompare;
    logic        hitMax;
    logic        setMatch;
    logic        setOvf;
    logic        clrMatch;
    logic        clrOvf;
    logic [31:0] ctrlView;
    logic [31:0] statusView;
    logic        unusedAddrBits;

    // Byte-lane merge used by every writable register
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  lanes);
        logic [31:0] mask;
        mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
        return (oldVal & ~mask) | (newVal & mask);
    endfunction

    assign unusedAddrBits = ^timer_address[1:0];

    // Access decode: a new access is taken only while no acknowledge is outstanding
    always_comb begin
        regSel    = timer_address[3:2];
        access    = timer_enable & ~ready_q;
        wrAny     = access & (timer_wr != 4'b0000);
        wrCtrl    = wrAny & (regSel == REG_CTRL);
        wrCount   = wrAny & (regSel == REG_COUNT);
        wrCompare = wrAny & (regSel == REG_COMPARE);
        wrStatus  = wrAny & (regSel == REG_STATUS);
        ctrlView  = {16'h0000, prescale_q, 5'b00000, irqEn_q, periodic_q, en_q};
        statusView = {30'h0, ovf_q, match_q};
    end

    // Tick and compare events; a bus write to COUNT suppresses the count update and flag sets
    always_comb begin
        tick       = en_q & (pcnt_q == prescale_q);
        hitCompare = (count_q == compare_q);
        hitMax     = &count_q;
        setMatch   = tick & ~wrCount & hitCompare;
        setOvf     = tick & ~wrCount & ~hitCompare & hitMax;
        clrMatch   = wrStatus & timer_wr[0] & timer_data_i[0];
        clrOvf     = wrStatus & timer_wr[0] & timer_data_i[1];
    end

    // CTRL next state: one-shot auto-stop first, then a bus write to the low byte overrides it
    always_comb begin
        en_d       = en_q;
        periodic_d = periodic_q;
        irqEn_d    = irqEn_q;
        prescale_d = prescale_q;
        if (setMatch && !periodic_q) begin
            en_d = 1'b0;
        end
        if (wrCtrl) begin
            if (timer_wr[0]) begin
                en_d       = timer_data_i[0];
                periodic_d = timer_data_i[1];
                irqEn_d    = timer_data_i[2];
            end
            if (timer_wr[1]) begin
                prescale_d = timer_data_i[15:8];
            end
        end
    end

    // Prescaler: restarts on any CTRL/COUNT write (which also covers EN rising), free-runs while enabled
    always_comb begin
        pcnt_d = pcnt_q;
        if (wrCtrl || wrCount) begin
            pcnt_d = 8'h00;
        end else if (en_q) begin
            if (tick) begin
                pcnt_d = 8'h00;
            end else begin
                pcnt_d = pcnt_q + 8'h01;
            end
        end
    end

    // COUNT/COMPARE next state: bus writes win over the tick update
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        if (wrCount) begin
            count_d = mergeBytes(count_q, timer_data_i, timer_wr);
        end else if (tick) begin
            if (hitCompare || hitMax) begin
                count_d = 32'h0000_0000;
            end else begin
                count_d = count_q + 32'h0000_0001;
            end
        end
        if (wrCompare) begin
            compare_d = mergeBytes(compare_q, timer_data_i, timer_wr);
        end
    end

    // Status flags: a new event beats a simultaneous write-1-to-clear
    always_comb begin
        match_d = (match_q & ~clrMatch) | setMatch;
        ovf_d   = (ovf_q & ~clrOvf) | setOvf;
    end

    // Read path: capture the pre-write register value on every accepted access
    always_comb begin
        ready_d = access;
        rdata_d = rdata_q;
        if (access) begin
            case (regSel)
                REG_CTRL:    rdata_d = ctrlView;
                REG_COUNT:   rdata_d = count_q;
                REG_COMPARE: rdata_d = compare_q;
                default:     rdata_d = statusView;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            irqEn_q    <= 1'b0;
            prescale_q <= 8'h00;
            pcnt_q     <= 8'h00;
            count_q    <= 32'h0000_0000;
            compare_q  <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0000_0000;
        end else begin
            en_q       <= en_d;
            periodic_q <= periodic_d;
            irqEn_q    <= irqEn_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            ovf_q      <= ovf_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    assign timer_data_o    = rdata_q;
    assign timer_ready     = ready_q;
    assign timer_interrupt = irqEn_q & (match_q | ovf_q);

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for the timer slave: a table of register accesses with
// expected read data, then hand-written multi-cycle sequences for periodic,
// one-shot, overflow, collision and asynchronous-reset behaviour.
module tb_timer;

    logic        clk;
    logic        rst;
    logic [3:0]  timer_address;
    logic [31:0] timer_data_i;
    logic [3:0]  timer_wr;
    logic        timer_enable;
    logic [31:0] timer_data_o;
    logic        timer_ready;
    logic        timer_interrupt;

    timer dut (
        .clk             (clk),
        .rst             (rst),
        .timer_address   (timer_address),
        .timer_data_i    (timer_data_i),
        .timer_wr        (timer_wr),
        .timer_enable    (timer_enable),
        .timer_data_o    (timer_data_o),
        .timer_ready     (timer_ready),
        .timer_interrupt (timer_interrupt)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wr;
        logic [31:0] exp;
        string       name;
    } vecT;

    typedef struct {
        bit          check;
        logic [31:0] exp;
        string       name;
    } sbItemT;

    sbItemT sbQueue[$];
    sbItemT monItem;
    vecT    vecs[18];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int lastAcceptCyc = 0;
    int anchor     = 0;
    logic prevReady = 1'b0;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter used to place accesses on exact cycles relative to an anchor write
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something wedges
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one access at the current negedge; the expected read data goes into the scoreboard
    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] wdata, input logic [3:0] wr,
                                 input logic [31:0] exp, input bit chk, input string name);
        sbItemT it;
        it.check = chk;
        it.exp   = exp;
        it.name  = name;
        sbQueue.push_back(it);
        lastAcceptCyc = cyc + 1;
        timer_address = addr;
        timer_data_i  = wdata;
        timer_wr      = wr;
        timer_enable  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, " ready"}, 32'(timer_ready), 32'd1);
        timer_enable = 1'b0;
        timer_wr     = 4'b0000;
        @(negedge clk);
    endtask

    task automatic readReg(input logic [3:0] addr, input logic [31:0] exp, input string name);
        applyStimulus(addr, 32'h0, 4'b0000, exp, 1'b1, name);
    endtask

    // Advance to the negedge that lies target cycles after the anchor accept edge
    task automatic waitK(input int target);
        int guard = 0;
        while ((cyc - anchor) < target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if ((cyc - anchor) != target)
            checkOutput("cycle alignment", 32'(cyc - anchor), 32'(target));
    endtask

    // Scoreboard: every acknowledge pops one expected entry; ready must never last two cycles
    always @(negedge clk) begin
        if (rst && timer_ready) begin
            checkOutput("ready pulse width", 32'(prevReady), 32'd0);
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected ready", 32'd1, 32'd0);
            end else begin
                monItem = sbQueue.pop_front();
                if (monItem.check)
                    checkOutput(monItem.name, timer_data_o, monItem.exp);
            end
        end
        prevReady = timer_ready;
    end

    initial begin
        rst           = 1'b0;
        timer_address = 4'h0;
        timer_data_i  = 32'h0;
        timer_wr      = 4'b0000;
        timer_enable  = 1'b0;

        // Register table with the timer disabled; write entries expect the pre-write value
        vecs[0]  = '{4'h0, 32'h0000_0000, 4'b0000, 32'h0000_0000, "rd CTRL reset"};
        vecs[1]  = '{4'h4, 32'h0000_0000, 4'b0000, 32'h0000_0000, "rd COUNT reset"};
        vecs[2]  = '{4'h8, 32'h0000_0000, 4'b0000, 32'hFFFF_FFFF, "rd COMPARE reset"};
        vecs[3]  = '{4'hC, 32'h0000_0000, 4'b0000, 32'h0000_0000, "rd STATUS reset"};
        vecs[4]  = '{4'h8, 32'h1234_5678, 4'b1111, 32'hFFFF_FFFF, "wr COMPARE full"};
        vecs[5]  = '{4'h8, 32'h0000_0000, 4'b0000, 32'h1234_5678, "rd COMPARE full"};
        vecs[6]  = '{4'h8, 32'hAABB_CCDD, 4'b0100, 32'h1234_5678, "wr COMPARE lane2"};
        vecs[7]  = '{4'h8, 32'h0000_0000, 4'b0000, 32'h12BB_5678, "rd COMPARE lane2"};
        vecs[8]  = '{4'h0, 32'h0000_0300, 4'b0010, 32'h0000_0000, "wr CTRL lane1"};
        vecs[9]  = '{4'h0, 32'h0000_0000, 4'b0000, 32'h0000_0300, "rd CTRL prescale"};
        vecs[10] = '{4'h0, 32'hFFFF_FFF8, 4'b1111, 32'h0000_0300, "wr CTRL reserved"};
        vecs[11] = '{4'h0, 32'h0000_0000, 4'b0000, 32'h0000_FF00, "rd CTRL reserved"};
        vecs[12] = '{4'h4, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, "wr COUNT"};
        vecs[13] = '{4'h4, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, "rd COUNT"};
        vecs[14] = '{4'hC, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, "wr STATUS"};
        vecs[15] = '{4'hC, 32'h0000_0000, 4'b0000, 32'h0000_0000, "rd STATUS"};
        vecs[16] = '{4'h6, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, "rd COUNT addr6"};
        vecs[17] = '{4'h0, 32'h0000_0000, 4'b1111, 32'h0000_FF00, "wr CTRL clear"};

        repeat (3) @(negedge clk);
        checkOutput("in reset ready", 32'(timer_ready), 32'd0);
        checkOutput("in reset data", timer_data_o, 32'd0);
        checkOutput("in reset irq", 32'(timer_interrupt), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++)
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].exp, 1'b1, vecs[i].name);
        applyStimulus(4'h4, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b1, "wr COUNT clear");

        // One-shot, PRESCALE=0, COMPARE=5
        applyStimulus(4'h8, 32'h5, 4'b1111, 32'h12BB_5678, 1'b1, "os wr COMPARE");
        applyStimulus(4'hC, 32'h3, 4'b1111, 32'h0, 1'b1, "os wr STATUS");
        applyStimulus(4'h0, 32'h5, 4'b1111, 32'h0, 1'b1, "os wr CTRL");
        anchor = lastAcceptCyc;
        readReg(4'h4, 32'd1, "os COUNT k1");
        readReg(4'h4, 32'd3, "os COUNT k3");
        checkOutput("os irq before match", 32'(timer_interrupt), 32'd0);
        @(negedge clk);
        checkOutput("os irq at match", 32'(timer_interrupt), 32'd1);
        readReg(4'h0, 32'h4, "os CTRL EN cleared");
        readReg(4'h4, 32'd0, "os COUNT after match");
        waitK(20);
        readReg(4'h4, 32'd0, "os COUNT stays 0");
        readReg(4'hC, 32'h1, "os STATUS");

        // Overflow with PRESCALE=3 so the 0xFFFF_FFFF step is observable
        applyStimulus(4'h8, 32'h10, 4'b1111, 32'h5, 1'b1, "ov wr COMPARE");
        applyStimulus(4'h4, 32'hFFFF_FFFE, 4'b1111, 32'h0, 1'b1, "ov wr COUNT");
        applyStimulus(4'hC, 32'h3, 4'b1111, 32'h1, 1'b1, "ov wr STATUS");
        applyStimulus(4'h0, 32'h301, 4'b1111, 32'h4, 1'b1, "ov wr CTRL");
        anchor = lastAcceptCyc;
        readReg(4'h4, 32'hFFFF_FFFE, "ov COUNT k1");
        waitK(4);
        readReg(4'h4, 32'hFFFF_FFFF, "ov COUNT max");
        readReg(4'hC, 32'h0, "ov STATUS before wrap");
        readReg(4'h4, 32'h0, "ov COUNT wrapped");
        readReg(4'hC, 32'h2, "ov STATUS OVF only");
        checkOutput("ov irq masked", 32'(timer_interrupt), 32'd0);
        applyStimulus(4'h0, 32'h5, 4'b1111, 32'h301, 1'b1, "ov wr CTRL irq");
        checkOutput("ov irq enabled", 32'(timer_interrupt), 32'd1);
        applyStimulus(4'h0, 32'h300, 4'b0010, 32'h5, 1'b1, "byte wr CTRL");
        readReg(4'h0, 32'h305, "rd CTRL after byte wr");
        applyStimulus(4'h0, 32'h0, 4'b1111, 32'h305, 1'b1, "ov stop");

        // Periodic, PRESCALE=2, COMPARE=3
        applyStimulus(4'h4, 32'h0, 4'b1111, 32'h0, 1'b0, "pd wr COUNT");
        applyStimulus(4'h8, 32'h3, 4'b1111, 32'h10, 1'b1, "pd wr COMPARE");
        applyStimulus(4'hC, 32'h3, 4'b1111, 32'h2, 1'b1, "pd wr STATUS");
        applyStimulus(4'h0, 32'h207, 4'b1111, 32'h0, 1'b1, "pd wr CTRL");
        anchor = lastAcceptCyc;
        waitK(11);
        checkOutput("pd irq before match", 32'(timer_interrupt), 32'd0);
        waitK(12);
        checkOutput("pd irq at match", 32'(timer_interrupt), 32'd1);
        for (int j = 0; j < 6; j++) begin
            int k;
            k = cyc - anchor;
            readReg(4'h4, 32'((k / 3) % 4), "pd COUNT step");
        end
        readReg(4'hC, 32'h1, "pd STATUS MATCH");
        checkOutput("pd irq held", 32'(timer_interrupt), 32'd1);
        applyStimulus(4'hC, 32'h1, 4'b0001, 32'h1, 1'b1, "pd W1C");
        checkOutput("pd irq after W1C", 32'(timer_interrupt), 32'd0);
        waitK(35);
        applyStimulus(4'hC, 32'h1, 4'b0001, 32'h0, 1'b1, "pd W1C on match");
        checkOutput("pd irq set wins", 32'(timer_interrupt), 32'd1);
        readReg(4'hC, 32'h1, "pd STATUS set wins");
        waitK(41);
        applyStimulus(4'h4, 32'h100, 4'b1111, 32'h1, 1'b1, "pd wr COUNT on tick");
        readReg(4'h4, 32'h100, "pd COUNT bus wins");
        checkOutput("pd irq before reset", 32'(timer_interrupt), 32'd1);

        // Asynchronous reset while an acknowledge is pending
        timer_address = 4'h4;
        timer_wr      = 4'b0000;
        timer_enable  = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("ready pending before reset", 32'(timer_ready), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("async reset ready", 32'(timer_ready), 32'd0);
        checkOutput("async reset data", timer_data_o, 32'd0);
        checkOutput("async reset irq", 32'(timer_interrupt), 32'd0);
        timer_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        readReg(4'h0, 32'h0, "post reset CTRL");
        repeat (5) @(negedge clk);
        readReg(4'h4, 32'h0, "post reset COUNT");
        readReg(4'h8, 32'hFFFF_FFFF, "post reset COMPARE");
        readReg(4'hC, 32'h0, "post reset STATUS");
        checkOutput("post reset irq", 32'(timer_interrupt), 32'd0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
